// File: rtl/dst_track_pipe.sv
// dst_track_pipe
//
// Tracks the destination-register bookkeeping of a classic five-stage
// pipeline through the ID/EX, EX/MEM and MEM/WB stage registers. It also
// detects the load-use hazard that needs a one-cycle ID/IF hold.
//
// Ports
//   clk_i           clock; all state updates on the rising edge
//   rst_n_i         asynchronous active-low reset; clears every stage register
//   ID_RegRs_i      source register number of the instruction in ID
//   ID_RegRt_i      source register number of the instruction in ID
//   ID_RegRd_i      destination register number of the instruction in ID
//   ID_RegWr_i      the ID instruction writes a register
//   ID_MemRd_i      the ID instruction is a load
//   Flush_i         squash the instruction entering ID/EX
//   EX_ALUres_i     EX-stage result, captured into EX/MEM
//   MEM_RdData_i    data-memory read data, selected into MEM/WB for loads
//   IDEX_RegRs_o    Rs of the instruction in EX (registered)
//   IDEX_RegRt_o    Rt of the instruction in EX (registered)
//   EXMEM_RegRd_o   Rd of the instruction in MEM (registered)
//   EXMEM_RegWr_o   RegWr of the instruction in MEM (registered)
//   EXMEM_ALUres_o  ALU result of the instruction in MEM (registered)
//   MEMWB_RegRd_o   Rd of the instruction in WB (registered)
//   MEMWB_RegWr_o   RegWr of the instruction in WB (registered)
//   MEMWB_WrData_o  write-back data of the instruction in WB (registered)
//   Stall_o         combinational load-use hazard / ID-IF hold request
//   StallCnt_o      saturating count of stalled cycles; this port exists only
//                   when DST_TRACK_STALL_CNT_EN is defined
//
// Handshake: there is no valid/ready pairing here. Stall_o is a one-way hold
// request to the upstream stages. While it is high, ID/EX takes a bubble and
// upstream must present the same ID instruction again on the next cycle.
//
// Optional feature macro: DST_TRACK_STALL_CNT_EN
module dst_track_pipe (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  ID_RegRs_i,
  input  logic [4:0]  ID_RegRt_i,
  input  logic [4:0]  ID_RegRd_i,
  input  logic        ID_RegWr_i,
  input  logic        ID_MemRd_i,
  input  logic        Flush_i,
  input  logic [31:0] EX_ALUres_i,
  input  logic [31:0] MEM_RdData_i,
  output logic [4:0]  IDEX_RegRs_o,
  output logic [4:0]  IDEX_RegRt_o,
  output logic [4:0]  EXMEM_RegRd_o,
  output logic        EXMEM_RegWr_o,
  output logic [4:0]  MEMWB_RegRd_o,
  output logic        MEMWB_RegWr_o,
  output logic [31:0] EXMEM_ALUres_o,
  output logic [31:0] MEMWB_WrData_o,
  output logic        Stall_o
`ifdef DST_TRACK_STALL_CNT_EN
  ,
  output logic [15:0] StallCnt_o
`endif
);

  // ID/EX fields that are not visible on a port
  logic [4:0] idex_rd;
  logic       idex_regwr;
  logic       idex_memrd;
  // EX/MEM field that is not visible on a port
  logic       exmem_memrd;

  // A load in EX whose result an ID source needs cannot be forwarded in time.
  // A destination of r0 never creates a dependency.
  assign Stall_o = idex_memrd && idex_regwr && (idex_rd != 5'd0) &&
                   ((idex_rd == ID_RegRs_i) || (idex_rd == ID_RegRt_i));

  // ID/EX: flush or stall inserts a bubble. A write to r0 is dropped here,
  // so later stages never see it as a real write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      IDEX_RegRs_o <= 5'd0;
      IDEX_RegRt_o <= 5'd0;
      idex_rd      <= 5'd0;
      idex_regwr   <= 1'b0;
      idex_memrd   <= 1'b0;
    end else if (Flush_i || Stall_o) begin
      IDEX_RegRs_o <= 5'd0;
      IDEX_RegRt_o <= 5'd0;
      idex_rd      <= 5'd0;
      idex_regwr   <= 1'b0;
      idex_memrd   <= 1'b0;
    end else begin
      IDEX_RegRs_o <= ID_RegRs_i;
      IDEX_RegRt_o <= ID_RegRt_i;
      idex_rd      <= ID_RegRd_i;
      idex_regwr   <= ID_RegWr_i && (ID_RegRd_i != 5'd0);
      idex_memrd   <= ID_MemRd_i;
    end
  end

  // EX/MEM and MEM/WB advance every cycle. Stall and flush act only on ID/EX.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      EXMEM_RegRd_o  <= 5'd0;
      EXMEM_RegWr_o  <= 1'b0;
      exmem_memrd    <= 1'b0;
      EXMEM_ALUres_o <= 32'd0;
      MEMWB_RegRd_o  <= 5'd0;
      MEMWB_RegWr_o  <= 1'b0;
      MEMWB_WrData_o <= 32'd0;
    end else begin
      EXMEM_RegRd_o  <= idex_rd;
      EXMEM_RegWr_o  <= idex_regwr;
      exmem_memrd    <= idex_memrd;
      EXMEM_ALUres_o <= EX_ALUres_i;
      MEMWB_RegRd_o  <= EXMEM_RegRd_o;
      MEMWB_RegWr_o  <= EXMEM_RegWr_o;
      MEMWB_WrData_o <= exmem_memrd ? MEM_RdData_i : EXMEM_ALUres_o;
    end
  end

`ifdef DST_TRACK_STALL_CNT_EN
  logic [15:0] stall_cnt;

  // Count every stalled edge, including those where a flush also wins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt <= 16'd0;
    end else if (Stall_o && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign StallCnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_dst_track_pipe.sv
// tb_dst_track_pipe
//
// Directed table-driven bench for dst_track_pipe. Each table row gives one
// cycle of ID/EX/MEM inputs, the expected Stall_o for those inputs and the
// expected registered outputs after the following rising edge. All expected
// values are worked out by hand from the pipeline rules. Hand-written
// sequences then cover asynchronous reset mid-cycle and resume after reset.
module tb_dst_track_pipe;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_wr, id_mr, flush;
  logic [31:0] ex_alu, mem_rd;
  logic [4:0]  idex_rs, idex_rt, exmem_rd, memwb_rd;
  logic        exmem_wr, memwb_wr, stall;
  logic [31:0] exmem_alu, memwb_dat;
`ifdef DST_TRACK_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  dst_track_pipe dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .ID_RegRs_i     (id_rs),
    .ID_RegRt_i     (id_rt),
    .ID_RegRd_i     (id_rd),
    .ID_RegWr_i     (id_wr),
    .ID_MemRd_i     (id_mr),
    .Flush_i        (flush),
    .EX_ALUres_i    (ex_alu),
    .MEM_RdData_i   (mem_rd),
    .IDEX_RegRs_o   (idex_rs),
    .IDEX_RegRt_o   (idex_rt),
    .EXMEM_RegRd_o  (exmem_rd),
    .EXMEM_RegWr_o  (exmem_wr),
    .MEMWB_RegRd_o  (memwb_rd),
    .MEMWB_RegWr_o  (memwb_wr),
    .EXMEM_ALUres_o (exmem_alu),
    .MEMWB_WrData_o (memwb_dat),
    .Stall_o        (stall)
`ifdef DST_TRACK_STALL_CNT_EN
    ,
    .StallCnt_o     (stall_cnt)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic        wr, mr, fl;
    logic [31:0] alu, rdd;
    logic        e_stall;
    logic [4:0]  e_x_rs, e_x_rt, e_m_rd;
    logic        e_m_wr;
    logic [31:0] e_m_alu;
    logic [4:0]  e_w_rd;
    logic        e_w_wr;
    logic [31:0] e_w_dat;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
    input logic wr, input logic mr, input logic fl,
    input logic [31:0] alu, input logic [31:0] rdd, input logic e_stall,
    input logic [4:0] x_rs, input logic [4:0] x_rt,
    input logic [4:0] m_rd, input logic m_wr, input logic [31:0] m_alu,
    input logic [4:0] w_rd, input logic w_wr, input logic [31:0] w_dat);
    vec_t v;
    v.rs = rs; v.rt = rt; v.rd = rd; v.wr = wr; v.mr = mr; v.fl = fl;
    v.alu = alu; v.rdd = rdd; v.e_stall = e_stall;
    v.e_x_rs = x_rs; v.e_x_rt = x_rt;
    v.e_m_rd = m_rd; v.e_m_wr = m_wr; v.e_m_alu = m_alu;
    v.e_w_rd = w_rd; v.e_w_wr = w_wr; v.e_w_dat = w_dat;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic wr, input logic mr, input logic fl,
                       input logic [31:0] alu, input logic [31:0] rdd);
    id_rs = rs; id_rt = rt; id_rd = rd; id_wr = wr; id_mr = mr; flush = fl;
    ex_alu = alu; mem_rd = rdd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_idex_rs"},   32'(idex_rs),   32'd0);
    check({tag, "_idex_rt"},   32'(idex_rt),   32'd0);
    check({tag, "_exmem_rd"},  32'(exmem_rd),  32'd0);
    check({tag, "_exmem_wr"},  32'(exmem_wr),  32'd0);
    check({tag, "_exmem_alu"}, exmem_alu,      32'd0);
    check({tag, "_memwb_rd"},  32'(memwb_rd),  32'd0);
    check({tag, "_memwb_wr"},  32'(memwb_wr),  32'd0);
    check({tag, "_memwb_dat"}, memwb_dat,      32'd0);
    check({tag, "_stall"},     32'(stall),     32'd0);
`ifdef DST_TRACK_STALL_CNT_EN
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
  endtask

  initial begin
    //               rs  rt  rd wr mr fl  alu           rdd           st  xrs xrt mrd mwr malu          wrd wwr wdat
    vecs[0]  = mk(1,  2,  5,  1, 0, 0, 32'h0,        32'h0,        0,  1,  2,  0,  0, 32'h0,        0,  0, 32'h0);
    vecs[1]  = mk(3,  4,  6,  1, 0, 0, 32'h11,       32'h0,        0,  3,  4,  5,  1, 32'h11,       0,  0, 32'h0);
    vecs[2]  = mk(1,  0,  8,  1, 1, 0, 32'h22,       32'h0,        0,  1,  0,  6,  1, 32'h22,       5,  1, 32'h11);
    // Rs=8 depends on the load to r8: one stall, bubble enters ID/EX
    vecs[3]  = mk(8,  9,  10, 1, 0, 0, 32'h100,      32'h0,        1,  0,  0,  8,  1, 32'h100,      6,  1, 32'h22);
    // held instruction captured; load data selected into MEM/WB
    vecs[4]  = mk(8,  9,  10, 1, 0, 0, 32'h33,       32'hDEADBEEF, 0,  8,  9,  0,  0, 32'h33,       8,  1, 32'hDEADBEEF);
    // load to r0: its write-enable is dropped
    vecs[5]  = mk(2,  3,  0,  1, 1, 0, 32'h44,       32'h55,       0,  2,  3,  10, 1, 32'h44,       0,  0, 32'h33);
    vecs[6]  = mk(0,  0,  7,  1, 0, 0, 32'h10,       32'hDEADBEEF, 0,  0,  0,  0,  0, 32'h10,       10, 1, 32'h44);
    vecs[7]  = mk(1,  1,  9,  1, 0, 0, 32'h10,       32'h77,       0,  1,  1,  7,  1, 32'h10,       0,  0, 32'h77);
    // non-load in MEM: ALU result wins over read data
    vecs[8]  = mk(2,  2,  2,  1, 0, 0, 32'h10,       32'hDEADBEEF, 0,  2,  2,  9,  1, 32'h10,       7,  1, 32'h10);
    // flush alone
    vecs[9]  = mk(4,  5,  6,  1, 1, 1, 32'h99,       32'h0,        0,  0,  0,  2,  1, 32'h99,       9,  1, 32'h10);
    vecs[10] = mk(0,  0,  12, 1, 1, 0, 32'hA0,       32'h0,        0,  0,  0,  0,  0, 32'hA0,       2,  1, 32'h99);
    // flush together with a load-use stall on Rt: a single bubble
    vecs[11] = mk(3,  12, 13, 1, 0, 1, 32'hB0,       32'hCC,       1,  0,  0,  12, 1, 32'hB0,       0,  0, 32'hA0);
    vecs[12] = mk(14, 15, 16, 1, 0, 0, 32'hC0,       32'h1234,     0,  14, 15, 0,  0, 32'hC0,       12, 1, 32'h1234);
  end

  // ---------------- test sequence ----------------
  initial begin
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    #2;
    check_all_zero("reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].wr, vecs[i].mr, vecs[i].fl,
            vecs[i].alu, vecs[i].rdd);
      #1;
      check($sformatf("row%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      check($sformatf("row%0d_idex_rs", i),   32'(idex_rs),  32'(vecs[i].e_x_rs));
      check($sformatf("row%0d_idex_rt", i),   32'(idex_rt),  32'(vecs[i].e_x_rt));
      check($sformatf("row%0d_exmem_rd", i),  32'(exmem_rd), 32'(vecs[i].e_m_rd));
      check($sformatf("row%0d_exmem_wr", i),  32'(exmem_wr), 32'(vecs[i].e_m_wr));
      check($sformatf("row%0d_exmem_alu", i), exmem_alu,     vecs[i].e_m_alu);
      check($sformatf("row%0d_memwb_rd", i),  32'(memwb_rd), 32'(vecs[i].e_w_rd));
      check($sformatf("row%0d_memwb_wr", i),  32'(memwb_wr), 32'(vecs[i].e_w_wr));
      check($sformatf("row%0d_memwb_dat", i), memwb_dat,     vecs[i].e_w_dat);
    end

`ifdef DST_TRACK_STALL_CNT_EN
    // stalls at rows 3 and 11 (the second also flushed)
    check("stall_cnt_after_table", 32'(stall_cnt), 32'd2);
`endif

    // Asynchronous reset mid-cycle while a stall is being requested.
    drive(0, 0, 20, 1, 1, 0, 32'h5A, 32'h0);
    @(posedge clk);
    #1;
    check("pre_rst_exmem_rd", 32'(exmem_rd), 32'd16);
    check("pre_rst_memwb_dat", memwb_dat, 32'hC0);
    drive(20, 0, 21, 1, 0, 0, 32'h0, 32'h0);
    #1;
    check("pre_rst_stall", 32'(stall), 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");

    // Release between edges, then the first edge captures normally.
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(5, 6, 7, 1, 0, 0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("resume_idex_rs", 32'(idex_rs), 32'd5);
    check("resume_idex_rt", 32'(idex_rt), 32'd6);
    check("resume_exmem_wr", 32'(exmem_wr), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("resume_exmem_rd", 32'(exmem_rd), 32'd7);
    check("resume_exmem_wr2", 32'(exmem_wr), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
